// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared instruction word types for the fetch/decode path
package inst_queue_pkg;
  typedef logic [31:0] word;
  localparam word NOP_WORD = 32'h0000_0000;
  typedef struct packed {
    logic validA;
    word  instA;
    logic validB;
    word  instB;
  } inst_pair_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: dual-issue circular fetch queue with optional NOP squeeze
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit DROP_NOP = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_validA,
  input  logic                     i_validB,
  input  word                      i_instA,
  input  word                      i_instB,
  output logic                     o_ready,
  input  logic [1:0]               i_deq,
  output word                      o_instA,
  output word                      o_instB,
  output logic                     o_validA,
  output logic                     o_validB,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  word             mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            drop, keep_a, keep_b, push;
  logic [1:0]      n_enq, req, n_deq;
  word             w0, w1;
  always_comb begin
    keep_a = i_validA && !(DROP_NOP && i_instA == NOP_WORD);
    keep_b = i_validB && !(DROP_NOP && i_instB == NOP_WORD);
    n_enq  = {1'b0, keep_a} + {1'b0, keep_b};
    w0     = keep_a ? i_instA : i_instB;
    w1     = i_instB;
    req    = i_deq == 2'd3 ? 2'd2 : i_deq;
    n_deq  = CW'(req) > count ? count[1:0] : req;
    push   = o_ready && (i_validA || i_validB);
  end
  assign o_ready  = count <= CW'(DEPTH - 2);
  assign o_validA = count >= CW'(1);
  assign o_validB = count >= CW'(2);
  assign o_instA  = o_validA ? mem[head] : NOP_WORD;
  assign o_instB  = o_validB ? mem[head + PW'(1)] : NOP_WORD;
  assign o_count  = count;
  assign o_drop   = drop;
  // storage is not reset; occupancy alone decides what is visible
  always_ff @(posedge i_clk) begin
    if (push && !i_flush) begin
      if (n_enq != 2'd0) mem[tail] <= w0;
      if (n_enq == 2'd2) mem[tail + PW'(1)] <= w1;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drop  <= 1'b0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drop  <= 1'b0;
    end else begin
      drop  <= !o_ready && (i_validA || i_validB);
      head  <= head + PW'(n_deq);
      tail  <= push ? tail + PW'(n_enq) : tail;
      count <= count + (push ? CW'(n_enq) : CW'(0)) - CW'(n_deq);
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vectors with a scoreboard of hand-computed post-edge outputs
module tb_inst_queue;
  import inst_queue_pkg::*;
  logic i_clk = 1'b0, i_rst = 1'b1, i_flush = 1'b0;
  logic i_validA = 1'b0, i_validB = 1'b0;
  word  i_instA = '0, i_instB = '0, o_instA, o_instB;
  logic [1:0] i_deq = 2'd0;
  logic o_ready, o_validA, o_validB, o_drop;
  logic [3:0] o_count;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       va;
    word        ia;
    logic       vb;
    word        ib;
    logic       rdy;
    logic       drp;
  } obs_t;
  obs_t sb_q[$];
  int   tag_q[$];
  int   tag = 0;

  localparam word A1 = 32'h0050_0093, B1 = 32'h00A0_0113, EB = 32'h0010_0073;
  localparam word X1 = 32'h1111_1111, X2 = 32'h2222_2222;
  function automatic word w(input int n);
    return 32'h1000_0000 + 32'(n);
  endfunction

  inst_queue #(.DEPTH(8), .DROP_NOP(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_validA(i_validA), .i_validB(i_validB), .i_instA(i_instA), .i_instB(i_instB),
    .o_ready(o_ready), .i_deq(i_deq), .o_instA(o_instA), .o_instB(o_instB),
    .o_validA(o_validA), .o_validB(o_validB), .o_count(o_count), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  function automatic obs_t snap();
    return '{o_count, o_validA, o_instA, o_validB, o_instB, o_ready, o_drop};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d vA=%b A=%h vB=%b B=%h rdy=%b drop=%b, want cnt=%0d vA=%b A=%h vB=%b B=%h rdy=%b drop=%b",
               name, act.cnt, act.va, act.ia, act.vb, act.ib, act.rdy, act.drp,
               exp.cnt, exp.va, exp.ia, exp.vb, exp.ib, exp.rdy, exp.drp);
    end
  endtask

  // monitor: compare the registered outputs just after each edge
  initial forever begin
    @(posedge i_clk);
    #1;
    if (sb_q.size() != 0) check($sformatf("vec%0d", tag_q.pop_front()), snap(), sb_q.pop_front());
  end

  task automatic vec(input logic fl, input logic va, input word ia, input logic vb, input word ib,
                     input logic [1:0] dq, input logic [3:0] cnt, input word ea, input word eb,
                     input logic drp);
    @(negedge i_clk);
    i_flush = fl; i_validA = va; i_instA = ia; i_validB = vb; i_instB = ib; i_deq = dq;
    tag++;
    tag_q.push_back(tag);
    sb_q.push_back('{cnt, cnt >= 1, ea, cnt >= 2, eb, cnt <= 6, drp});
  endtask

  initial begin
    #2;
    check("reset", snap(), '{4'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
    @(negedge i_clk);
    i_rst = 1'b0;
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, 1, A1, 1, B1, 0, 2, A1, B1, 0);
    vec(0, 0, 0, 0, 0, 1, 1, B1, 0, 0);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vec(0, 1, w(1), 1, w(2), 0, 2, w(1), w(2), 0);
    vec(0, 1, w(3), 1, w(4), 0, 4, w(1), w(2), 0);
    vec(0, 1, w(5), 1, w(6), 0, 6, w(1), w(2), 0);
    vec(0, 1, w(7), 1, w(8), 2, 6, w(3), w(4), 0);
    vec(0, 1, w(9), 0, 0, 0, 7, w(3), w(4), 0);
    vec(0, 1, X1, 1, X2, 0, 7, w(3), w(4), 1);
    vec(0, 0, 0, 0, 0, 0, 7, w(3), w(4), 0);
    vec(0, 0, 0, 0, 0, 2, 5, w(5), w(6), 0);
    vec(0, 0, 0, 0, 0, 2, 3, w(7), w(8), 0);
    vec(0, 0, 0, 0, 0, 2, 1, w(9), 0, 0);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vec(0, 1, w(10), 1, w(11), 0, 2, w(10), w(11), 0);
    vec(0, 1, w(12), 1, w(13), 2, 2, w(12), w(13), 0);
    vec(0, 1, w(14), 1, w(15), 2, 2, w(14), w(15), 0);
    vec(0, 1, 0, 1, EB, 2, 1, EB, 0, 0);
    vec(0, 1, 0, 1, 0, 0, 1, EB, 0, 0);
    vec(0, 1, w(16), 1, 0, 0, 2, EB, w(16), 0);
    vec(0, 1, w(17), 1, w(18), 0, 4, EB, w(16), 0);
    vec(0, 1, w(19), 0, 0, 0, 5, EB, w(16), 0);
    vec(1, 1, w(20), 1, w(21), 2, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, 1, w(22), 1, w(23), 0, 2, w(22), w(23), 0);
    vec(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    vec(0, 1, w(24), 0, 0, 0, 1, w(24), 0, 0);
    vec(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    vec(0, 1, w(25), 1, w(26), 0, 2, w(25), w(26), 0);
    @(negedge i_clk);
    i_validA = 0; i_validB = 0; i_deq = 0; i_flush = 0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge i_clk);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries never observed, want 0", sb_q.size());
    end
    #2 i_rst = 1'b1;
    #1;
    check("async_rst", snap(), '{4'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Dual-issue instruction fetch queue between the dual-word instruction ROM and the dual decoder.
- Each cycle it accepts 0–2 instruction words from fetch and presents the two oldest entries to decode, in order.
- Decoupled from decode stalls by a circular buffer.
- Optionally squeezes out all-zero NOP words, which the ROM emits at end of program.

Parameters:
- DEPTH, 8, number of word entries; power of two, at least 4.
- DROP_NOP, 1, when 1 an incoming word equal to 32'h0 is discarded instead of enqueued.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_flush  input  1  synchronous queue clear (branch redirect)
- i_validA  input  1  i_instA carries an instruction (older of the pair)
- i_validB  input  1  i_instB carries an instruction (younger)
- i_instA  input  word  fetched instruction A
- i_instB  input  word  fetched instruction B
- o_ready  output  1  fetch may present a pair this cycle
- i_deq  input  2  number of head entries decode consumes this cycle (0, 1 or 2)
- o_instA  output  word  head entry (oldest)
- o_instB  output  word  head+1 entry
- o_validA  output  1  o_instA valid
- o_validB  output  1  o_instB valid
- o_count  output  $clog2(DEPTH)+1  current occupancy
- o_drop  output  1  one-cycle pulse: a push arrived while not ready and was lost

Behaviour:
- State is a storage array, head pointer, tail pointer and count register. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (async, i_rst=1):
  - head=tail=count=0; o_drop=0.
  - Outputs therefore read o_validA=o_validB=0, o_instA=o_instB=0, o_ready=1, o_count=0.
  - Array contents are don't-care.
- o_ready = (count <= DEPTH-2), combinational from the registered count. It does not depend on same-cycle i_deq.
- Enqueue filter:
  - Word A is "kept" when i_validA && !(DROP_NOP && i_instA==0). Word B is kept by the same rule.
  - n_enq = number of kept words, 0..2.
  - Kept words are written in age order at tail, tail+1. If A is filtered and B kept, B goes to tail.
- A push occurs only when o_ready=1. If o_ready=0 and (i_validA|i_validB), nothing is written and o_drop=1 next cycle. Filtered NOPs alone still count as a push for this rule.
- Dequeue:
  - n_deq = min(i_deq, count). Over-requesting is clamped, never underflows.
  - i_deq=3 is treated as 2.
- Update each rising edge:
  - head += n_deq; tail += n_enq; count = count + n_enq - n_deq.
  - Simultaneous enqueue and dequeue in the same cycle is legal at any occupancy where o_ready=1.
- Read side (show-ahead, combinational from registers):
  - o_instA = mem[head] if count>=1, else 0.
  - o_instB = mem[head+1 mod DEPTH] if count>=2, else 0.
  - o_validA = count>=1; o_validB = count>=2.
- Flush (i_flush=1 at an edge): head=tail=count=0 next cycle, overriding any same-cycle enqueue and dequeue. o_drop is not asserted by a flush.
- Reset asserted mid-operation: immediate clear regardless of clock. No partial state survives.
- Write pointer wrap: a pair straddling the array end splits across index DEPTH-1 and 0.
- Latency: a word enqueued at edge N is visible on o_instA/B after edge N, i.e. in cycle N+1. There is no bypass from input to output in the same cycle.

Decomposition:
- Use the existing `word` type from Types.
- Add to Types:
  - NOP_WORD = 32'h0000_0000.
  - typedef inst_pair_t, a struct with validA, instA, validB, instB. Used later for fetch/decode bundles.
- No sub-module is needed. The filter/compaction logic is small; keep it inline as an always_comb block.

Test Plan:
- Reset then idle → o_count=0, o_validA=o_validB=0, o_ready=1, outputs 0.
- Push A=0x00500093, B=0x00A00113 with i_deq=0 → next cycle o_count=2, o_instA=0x00500093, o_instB=0x00A00113, both valid. Then i_deq=1 → o_instA=0x00A00113, o_validB=0.
- DEPTH=8: push 3 pairs, then push another with i_deq=2 in the same cycle → o_count goes 6→6. The fourth pair's entries wrap to indices 6,7. Continuing pushes wrap the tail to 0 with data order intact.
- Fill to count=7 → o_ready=0. A further push of pair 0x11111111/0x22222222 → o_drop pulses 1 cycle, o_count stays 7, and neither word appears at the output.
- DROP_NOP=1: push A=0x0, B=0x00100073 → o_count=1, o_instA=0x00100073. Push A=0, B=0 → o_count unchanged.
- With count=5, assert i_flush together with a valid push and i_deq=2 → next cycle o_count=0, outputs invalid. Asserting i_rst between clock edges clears o_validA immediately.
